jelly3_sum_tree_gather: RTL and testbench

//  Serial-to-parallel front end for jelly3_sum_tree. Collects a stream of scalar

---
 rtl/jelly3_sum_tree_pkg.sv | 20 ++
 rtl/jelly3_sum_tree_gather.sv | 88 ++++++++
 tb/tb_jelly3_sum_tree_gather.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jelly3_sum_tree_pkg.sv
// Shared definitions for the jelly3 sum-tree family (gather front end and sum_tree).
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Holds the default sample/sideband widths and the lane-count width helper so
// the gather stage and the sum_tree agree on m_count/s_count sizing.
package jelly3_sum_tree_pkg;

  localparam int DEF_S_DATA_BITS = 8;
  localparam int DEF_USER_BITS   = 8;

  typedef logic signed [DEF_S_DATA_BITS-1:0] def_s_data_t;
  typedef logic        [DEF_USER_BITS-1:0]   def_user_t;

  // Width needed to hold a count in 0..n inclusive.
  function automatic int count_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jelly3_sum_tree_gather.sv
// Serial-to-parallel gather: packs accepted scalar beats into an N-lane vector.
// Latency: m_valid rises the cke-cycle after the completing beat (N beats or s_last).
// Backpressure: none internally; s_ready mirrors cke, so everything freezes while cke=0.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   cke                clock enable shared with the downstream sum_tree
//   s_data/s_en/s_user/s_last/s_valid/s_ready   scalar input stream
//   m_en/m_data/m_user/m_last/m_count/m_valid   vector output (sum_tree s_* side)
module jelly3_sum_tree_gather
  import jelly3_sum_tree_pkg::*;
#(
  parameter int  N           = 16,
  parameter int  S_DATA_BITS = DEF_S_DATA_BITS,
  parameter type s_data_t    = logic signed [S_DATA_BITS-1:0],
  parameter int  USER_BITS   = DEF_USER_BITS,
  parameter type user_t      = logic [USER_BITS-1:0],
  parameter int  COUNT_BITS  = count_bits(N)
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,

  input  s_data_t               s_data,
  input  logic                  s_en,
  input  user_t                 s_user,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,

  output logic    [N-1:0]       m_en,
  output s_data_t [N-1:0]       m_data,
  output user_t                 m_user,
  output logic                  m_last,
  output logic [COUNT_BITS-1:0] m_count,
  output logic                  m_valid
);

  // idx needs at least one bit even for a single-lane build.
  localparam int                  IDX_BITS = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(N - 1);

  logic [IDX_BITS-1:0] idx;

  assign s_ready = cke;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      m_en    <= '0;
      m_data  <= '0;
      m_user  <= '0;
      m_last  <= 1'b0;
      m_count <= '0;
      m_valid <= 1'b0;
    end else if (cke) begin
      m_valid <= 1'b0;
      if (s_valid) begin
        // The first beat of a vector also wipes the remaining lanes, so a
        // short vector leaves en=0/data=0 padding behind it. Lanes are only
        // touched by accepts, which keeps them stable through the m_valid cycle.
        for (int i = 0; i < N; i++) begin
          if (i == int'(idx)) begin
            m_data[i] <= s_data;
            m_en[i]   <= s_en;
          end else if (idx == '0) begin
            m_data[i] <= '0;
            m_en[i]   <= 1'b0;
          end
        end

        if (idx == '0) begin
          m_user <= s_user;
        end

        if (s_last || idx == IDX_LAST) begin
          m_valid <= 1'b1;
          m_last  <= s_last;
          m_count <= COUNT_BITS'(idx) + COUNT_BITS'(1);
          idx     <= '0;
        end else begin
          idx     <= idx + IDX_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_jelly3_sum_tree_gather.sv
// Self-checking bench for jelly3_sum_tree_gather (N=4, 8-bit samples).
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_jelly3_sum_tree_gather;

  localparam int N = 4;

  logic                  clk;
  logic                  reset;
  logic                  cke;
  logic signed [7:0]     s_data;
  logic                  s_en;
  logic [7:0]            s_user;
  logic                  s_last;
  logic                  s_valid;
  logic                  s_ready;
  logic [N-1:0]          m_en;
  logic [N-1:0][7:0]     m_data;
  logic [7:0]            m_user;
  logic                  m_last;
  logic [2:0]            m_count;
  logic                  m_valid;

  jelly3_sum_tree_gather #(
    .N           (N),
    .S_DATA_BITS (8),
    .USER_BITS   (8)
  ) dut (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
    .s_data  (s_data),
    .s_en    (s_en),
    .s_user  (s_user),
    .s_last  (s_last),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_en    (m_en),
    .m_data  (m_data),
    .m_user  (m_user),
    .m_last  (m_last),
    .m_count (m_count),
    .m_valid (m_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- behavioural model: queue of expected vectors ----------------
  typedef struct {
    logic [N-1:0]      en;
    logic [N-1:0][7:0] data;
    logic [7:0]        user;
    logic              last;
    int                count;
    int                sum;
  } vec_t;

  vec_t exp_q[$];
  vec_t cur;
  int   cur_n = 0;
  int   cyc   = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      cur_n = 0;
    end else if (cke && s_valid) begin
      if (cur_n == 0) begin
        cur.en   = '0;
        cur.data = '0;
        cur.user = s_user;
        cur.sum  = 0;
      end
      cur.en[cur_n]   = s_en;
      cur.data[cur_n] = s_data;
      if (s_en) cur.sum += int'(s_data);
      cur_n++;
      if (s_last || cur_n == N) begin
        cur.last  = s_last;
        cur.count = cur_n;
        exp_q.push_back(cur);
        cur_n = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  int                pulses = 0;
  int                pulse_cyc[$];
  logic [N-1:0]      last_en;
  logic [N-1:0][7:0] last_data;
  logic [7:0]        last_user;
  logic              last_last;
  int                last_count;
  int                last_sum;

  always @(negedge clk) begin
    if (!reset) begin
      chk("s_ready_eq_cke", s_ready, cke);
      // A vector is consumed downstream on a cke cycle where m_valid is high.
      if (m_valid && cke) begin
        vec_t e;
        int   dsum;
        pulses++;
        pulse_cyc.push_back(cyc);
        dsum = 0;
        for (int i = 0; i < N; i++) if (m_en[i]) dsum += int'($signed(m_data[i]));
        last_en    = m_en;
        last_data  = m_data;
        last_user  = m_user;
        last_last  = m_last;
        last_count = int'(m_count);
        last_sum   = dsum;
        chk("vec_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("m_en",    m_en,    e.en);
          chk("m_data",  m_data,  e.data);
          chk("m_user",  m_user,  e.user);
          chk("m_last",  m_last,  e.last);
          chk("m_count", m_count, e.count);
          chk("sum",     dsum,    e.sum);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [7:0] d, input logic e,
                       input logic [7:0] u, input logic l, input logic c);
    s_valid = v;
    s_data  = d;
    s_en    = e;
    s_user  = u;
    s_last  = l;
    cke     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int   p0;
  logic c, v, done, lst;
  int   len;

  initial begin
    reset = 1'b1; cke = 1'b1; s_valid = 1'b0; s_data = '0; s_en = 1'b0; s_user = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_en",    m_en,    0);
    chk("rst_m_data",  m_data,  0);
    chk("rst_m_user",  m_user,  0);
    chk("rst_m_last",  m_last,  0);
    chk("rst_m_count", m_count, 0);
    @(posedge clk); #1;

    // 1: full vector 1,2,3,4
    p0 = pulses;
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b1, 8'h11, 1'b0, 1'b1);
    idle(3);
    chk("t1_pulses", pulses - p0, 1);
    chk("t1_data",   last_data, 32'h04030201);
    chk("t1_en",     last_en, 4'b1111);
    chk("t1_count",  last_count, 4);
    chk("t1_last",   last_last, 0);
    chk("t1_user",   last_user, 8'h11);

    // 2: short vector 5,-6 closed by s_last
    p0 = pulses;
    drive(1'b1, 8'd5,  1'b1, 8'h22, 1'b0, 1'b1);
    drive(1'b1, 8'hFA, 1'b1, 8'h33, 1'b1, 1'b1);
    idle(3);
    chk("t2_pulses", pulses - p0, 1);
    chk("t2_en",     last_en, 4'b0011);
    chk("t2_data",   last_data, 32'h0000FA05);
    chk("t2_count",  last_count, 2);
    chk("t2_last",   last_last, 1);
    chk("t2_user",   last_user, 8'h22);
    chk("t2_sum",    last_sum, -1);

    // 3: random cke and s_valid gaps, 10 beats forming 3 vectors (3 + 4 + 3)
    p0 = pulses;
    for (int b = 0; b < 10; b++) begin
      done = 1'b0;
      for (int t = 0; t < 20 && !done; t++) begin
        c = 1'($urandom_range(0, 1));
        v = 1'($urandom_range(0, 1));
        if (t == 19) begin c = 1'b1; v = 1'b1; end
        drive(v, 8'(b * 3 + 1), 1'b1, 8'(b), (b == 2 || b == 9), c);
        done = c && v;
      end
    end
    idle(3);
    chk("t3_pulses", pulses - p0, 3);

    // 4: 12 back-to-back beats, en alternating 1,0
    p0 = pulses;
    for (int i = 0; i < 12; i++) drive(1'b1, 8'(i + 1), 1'((i + 1) % 2), 8'h44, 1'b0, 1'b1);
    idle(3);
    chk("t4_pulses", pulses - p0, 3);
    chk("t4_en",     last_en, 4'b0101);
    if (pulses - p0 == 3) begin
      chk("t4_gap_a", pulse_cyc[p0 + 1] - pulse_cyc[p0], 4);
      chk("t4_gap_b", pulse_cyc[p0 + 2] - pulse_cyc[p0 + 1], 4);
    end

    // 5: reset after two beats discards them, then 7,8,9,10
    p0 = pulses;
    drive(1'b1, 8'd1, 1'b1, 8'h55, 1'b0, 1'b1);
    drive(1'b1, 8'd2, 1'b1, 8'h55, 1'b0, 1'b1);
    reset = 1'b1;
    idle(2);
    chk("t5_valid_in_reset", m_valid, 0);
    chk("t5_pulses_reset",   pulses - p0, 0);
    reset = 1'b0;
    for (int i = 7; i <= 10; i++) drive(1'b1, 8'(i), 1'b1, 8'h66, 1'b0, 1'b1);
    idle(3);
    chk("t5_pulses", pulses - p0, 1);
    chk("t5_data",   last_data, 32'h0A090807);
    chk("t5_user",   last_user, 8'h66);

    // 6: 200 random vectors, random lengths/last/en and occasional gaps
    p0 = pulses;
    for (int vi = 0; vi < 200; vi++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) drive(1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)));
        lst = (b == len - 1) && (len < 4 || $urandom_range(0, 1) == 1);
        drive(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), lst, 1'b1);
      end
    end
    idle(3);
    chk("t6_pulses", pulses - p0, 200);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
